axis_helper_reader: RTL and testbench



---
 rtl/axis_tb_pkg.sv | 34 +++
 rtl/axis_helper_reader.sv | 135 +++++++++++++
 tb/tb_axis_helper_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/axis_tb_pkg.sv
// axis_tb_pkg: shared helpers for in-memory AXI-Stream test infrastructure.
//   NULL_FILE_NAME        - name meaning "no sample file configured"
//   bytes_per_sample(w)   - bytes occupied by one w-bit sample in a binary fixture
//   sample_store          - named in-memory sample fixtures (byte contents)
//   write_text_fixture    - stores a text sample fixture, returns 1 on success
//   write_byte_fixture    - stores n raw bytes (MSB first), returns 1 on success
package axis_tb_pkg;

  localparam string NULL_FILE_NAME = "";

  byte unsigned sample_store[string][$];

  function automatic int unsigned bytes_per_sample(input int unsigned width);
    return (width + 32'd7) / 32'd8;
  endfunction

  // Stores a small text fixture for stimulus.
  function automatic bit write_text_fixture(input string path, input string text);
    if (path == NULL_FILE_NAME) return 1'b0;
    sample_store[path] = {};
    for (int i = 0; i < text.len(); i++) sample_store[path].push_back(text[i]);
    return 1'b1;
  endfunction

  // Stores a raw binary fixture from the low n bytes of a word, high byte first.
  function automatic bit write_byte_fixture(input string path, input bit [63:0] bytes,
                                            input int unsigned n);
    if (path == NULL_FILE_NAME) return 1'b0;
    sample_store[path] = {};
    for (int i = int'(n) - 1; i >= 0; i--) sample_store[path].push_back(bytes[i*8 +: 8]);
    return 1'b1;
  endfunction

endpackage

// File: rtl/axis_helper_reader.sv
// axis_helper_reader: simulation-only AXI-Stream source replaying samples from a
// named fixture (hex text tokens or raw big-endian binary) onto a valid/ready bus.
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset; rewinds the fixture and preloads
//   enable       - 0 pauses the stream (valid forced low, nothing consumed)
//   output_valid - a sample is being presented
//   output_data  - current sample, stable until handshaked
//   output_ready - consumer accepts the sample together with output_valid
module axis_helper_reader
  import axis_tb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter string       FILE_NAME  = NULL_FILE_NAME,
  parameter int          SKIP       = 0,
  parameter bit          BINARY     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  output_valid,
  output logic [DATA_WIDTH-1:0] output_data,
  input  logic                  output_ready
);

  localparam int unsigned BPS   = bytes_per_sample(DATA_WIDTH);
  localparam int unsigned ACC_W = BPS * 8;

  bit                    open_ok     = 1'b0;
  int                    pos         = 0;
  logic [DATA_WIDTH-1:0] data        = '0;
  logic                  have_sample = 1'b0;
  logic                  eof         = 1'b0;

  // A failed open leaves open_ok at 0, which keeps the holding register empty forever.
  initial begin
    pos     = 0;
    open_ok = (FILE_NAME != NULL_FILE_NAME) && sample_store.exists(FILE_NAME);
    if (!open_ok) $error("axis_helper_reader: cannot open sample file '%s'", FILE_NAME);
  end

  // Next unread byte, or -1 at end of data.
  function automatic int peek_byte();
    if (!open_ok) return -1;
    if (pos < sample_store[FILE_NAME].size()) return int'(sample_store[FILE_NAME][pos]);
    return -1;
  endfunction

  function automatic bit is_space(input int c);
    return (c == 32) || (c == 9) || (c == 10) || (c == 13) || (c == 11) || (c == 12);
  endfunction

  // Hex digit value, 16 for an underscore separator, -1 otherwise.
  function automatic int hex_val(input int c);
    if (c >= 48 && c <= 57)  return c - 48;
    if (c >= 65 && c <= 70)  return c - 55;
    if (c >= 97 && c <= 102) return c - 87;
    if (c == 95)             return 16;
    return -1;
  endfunction

  // Fetches one sample; ok=0 on end of data, a malformed token or a short binary tail.
  task automatic read_sample(output logic [DATA_WIDTH-1:0] d, output logic ok);
    logic [ACC_W-1:0] acc;
    int               c;
    int               v;
    int               nd;
    d   = '0;
    ok  = 1'b0;
    acc = '0;
    if (!open_ok) return;
    if (BINARY) begin
      ok = 1'b1;
      for (int i = 0; i < int'(BPS); i++) begin
        c = peek_byte();
        if (c < 0) ok = 1'b0;
        else begin
          acc = (acc << 8) | ACC_W'(c[7:0]);
          pos++;
        end
      end
      d = DATA_WIDTH'(acc);
    end else begin
      c = peek_byte();
      while (c >= 0 && is_space(c)) begin
        pos++;
        c = peek_byte();
      end
      nd = 0;
      while (c >= 0) begin
        v = hex_val(c);
        if (v < 0) break;
        if (v != 16) begin
          d = (d << 4) | DATA_WIDTH'(v);
          nd++;
        end
        pos++;
        c = peek_byte();
      end
      ok = (nd > 0);
    end
  endtask

  // Rewinds, drops the leading SKIP samples and returns the first remaining one.
  task automatic preload(output logic [DATA_WIDTH-1:0] d, output logic ok);
    d  = '0;
    ok = open_ok;
    if (!ok) return;
    pos = 0;
    for (int i = 0; i < SKIP && ok; i++) read_sample(d, ok);
    if (ok) read_sample(d, ok);
    if (!ok) d = '0;
  endtask

  // Reset reloads; a handshake replaces the sample at the same edge (no bubble).
  always @(posedge clk) begin : advance
    logic [DATA_WIDTH-1:0] d;
    logic                  ok;
    if (rst) begin
      preload(d, ok);
      data        <= d;
      have_sample <= ok;
      eof         <= ~ok;
    end else if (output_valid && output_ready && !eof) begin
      read_sample(d, ok);
      if (ok) data <= d;
      have_sample <= ok;
      eof         <= ~ok;
    end
  end

  assign output_valid = have_sample & enable & ~rst;
  assign output_data  = data;

endmodule

// File: tb/tb_axis_helper_reader.sv
// tb_axis_helper_reader: scoreboard bench for axis_helper_reader covering text and
// binary formats, SKIP, back-pressure, enable pauses and mid-stream reset.
module tb_axis_helper_reader;
  import axis_tb_pkg::*;

  localparam string TXT_FILE = "tb_axis_helper_reader_txt.hex";
  localparam string BIN_FILE = "tb_axis_helper_reader_bin.dat";

  // Fixtures exist before any reader opens its file at time 0.
  bit fixtures_ok = write_text_fixture(TXT_FILE, "0A 1F 3FF 002\n")
                  & write_byte_fixture(BIN_FILE, 64'h0000_0000_0123_0FFF, 4);

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        enable = 1'b1;
  logic        ready  = 1'b0;
  logic [3:0]  valid;
  logic [9:0]  d_txt, d_s2, d_s5;
  logic [11:0] d_bin;

  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] txt_vals[4] = '{12'h00A, 12'h01F, 12'h3FF, 12'h002};

  always #5 clk = ~clk;

  axis_helper_reader #(.DATA_WIDTH(10), .FILE_NAME(TXT_FILE), .SKIP(0), .BINARY(1'b0)) u_txt (
    .clk(clk), .rst(rst), .enable(enable), .output_valid(valid[0]),
    .output_data(d_txt), .output_ready(ready));

  axis_helper_reader #(.DATA_WIDTH(10), .FILE_NAME(TXT_FILE), .SKIP(2), .BINARY(1'b0)) u_skip2 (
    .clk(clk), .rst(rst), .enable(enable), .output_valid(valid[1]),
    .output_data(d_s2), .output_ready(ready));

  axis_helper_reader #(.DATA_WIDTH(10), .FILE_NAME(TXT_FILE), .SKIP(5), .BINARY(1'b0)) u_skip5 (
    .clk(clk), .rst(rst), .enable(enable), .output_valid(valid[2]),
    .output_data(d_s5), .output_ready(ready));

  axis_helper_reader #(.DATA_WIDTH(12), .FILE_NAME(BIN_FILE), .SKIP(0), .BINARY(1'b1)) u_bin (
    .clk(clk), .rst(rst), .enable(enable), .output_valid(valid[3]),
    .output_data(d_bin), .output_ready(ready));

  function automatic logic [11:0] obs_data(input int sel);
    case (sel)
      0:       return 12'(d_txt);
      1:       return 12'(d_s2);
      2:       return 12'(d_s5);
      default: return d_bin;
    endcase
  endfunction

  // Reference model of the text file: samples from index skip onward.
  function automatic void load_txt(input int skip);
    exp_q.delete();
    for (int i = skip; i < 4; i++) exp_q.push_back(txt_vals[i]);
  endfunction

  // One clock: drive at negedge, check just after, retire a sample on handshake.
  task automatic cycle(input int sel, input logic r, input logic en, input logic rdy,
                       input string tag);
    logic exp_v;
    logic [11:0] got;
    @(negedge clk);
    rst = r; enable = en; ready = rdy;
    #1;
    exp_v = !r && en && (exp_q.size() != 0);
    n_vec++;
    if (valid[sel] !== exp_v) begin
      n_err++;
      $display("FAIL %s valid: got %b want %b (t=%0t)", tag, valid[sel], exp_v, $time);
    end
    if (!r && exp_q.size() != 0) begin
      got = obs_data(sel);
      n_vec++;
      if (got !== exp_q[0]) begin
        n_err++;
        $display("FAIL %s data: got %h want %h (t=%0t)", tag, got, exp_q[0], $time);
      end
    end
    if (exp_v && rdy) void'(exp_q.pop_front());
  endtask

  // Holds reset over one edge with ready high, then checks the preloaded state.
  task automatic do_reset(input int sel, input logic [11:0] first, input string tag);
    logic [11:0] got;
    @(negedge clk);
    rst = 1'b1; enable = 1'b1; ready = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (valid[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL %s reset valid: got %b want 0", tag, valid[sel]);
    end
    got = obs_data(sel);
    n_vec++;
    if (got !== first) begin
      n_err++;
      $display("FAIL %s reset data: got %h want %h", tag, got, first);
    end
  endtask

  task automatic check_drained(input string tag);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s drained: got %0d samples left want 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (!fixtures_ok) begin
      n_err++;
      $display("FAIL fixtures: got %b want 1", fixtures_ok);
    end
    do_reset(0, 12'h00A, "reset");
  endtask

  task automatic test_stream();
    do_reset(0, 12'h00A, "stream");
    load_txt(0);
    repeat (7) cycle(0, 1'b0, 1'b1, 1'b1, "stream");
    check_drained("stream");
  endtask

  task automatic test_ready_toggle();
    logic pat[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset(0, 12'h00A, "ready_toggle");
    load_txt(0);
    foreach (pat[i]) cycle(0, 1'b0, 1'b1, pat[i], "ready_toggle");
    check_drained("ready_toggle");
  endtask

  task automatic test_skip();
    do_reset(1, 12'h3FF, "skip2");
    load_txt(2);
    repeat (4) cycle(1, 1'b0, 1'b1, 1'b1, "skip2");
    check_drained("skip2");
    do_reset(2, 12'h000, "skip5");
    load_txt(5);
    repeat (4) cycle(2, 1'b0, 1'b1, 1'b1, "skip5");
  endtask

  task automatic test_binary();
    do_reset(3, 12'h123, "binary");
    exp_q.delete();
    exp_q.push_back(12'h123);
    exp_q.push_back(12'hFFF);
    repeat (4) cycle(3, 1'b0, 1'b1, 1'b1, "binary");
    check_drained("binary");
  endtask

  task automatic test_enable_pause();
    do_reset(0, 12'h00A, "enable");
    load_txt(0);
    cycle(0, 1'b0, 1'b1, 1'b1, "enable");
    repeat (3) cycle(0, 1'b0, 1'b0, 1'b1, "enable_off");
    repeat (5) cycle(0, 1'b0, 1'b1, 1'b1, "enable");
    check_drained("enable");
  endtask

  task automatic test_back_to_back_reset();
    do_reset(0, 12'h00A, "midreset");
    load_txt(0);
    repeat (2) cycle(0, 1'b0, 1'b1, 1'b1, "midreset_pre");
    // Reset with ready high: the pending 0x3FF must not be consumed.
    cycle(0, 1'b1, 1'b1, 1'b1, "midreset_rst");
    load_txt(0);
    repeat (6) cycle(0, 1'b0, 1'b1, 1'b1, "midreset_post");
    check_drained("midreset");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ready_toggle();
    test_skip();
    test_binary();
    test_enable_pause();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
